// File: rtl/gat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gat_pkg
//  Description : Shared run-state encoding and new-feature BRAM geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package gat_pkg;

    localparam int GAT_NUM_SUBGRAPHS      = 2708;
    localparam int GAT_NUM_FEATURE_OUT    = 16;
    localparam int GAT_NEW_FEATURE_DEPTH  = GAT_NUM_SUBGRAPHS * GAT_NUM_FEATURE_OUT;
    localparam int GAT_NEW_FEATURE_ADDR_W = $clog2(GAT_NEW_FEATURE_DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOAD = 3'd1,
        START     = 3'd2,
        RUN       = 3'd3,
        DONE      = 3'd4
    } gat_run_state_t;

endpackage
`default_nettype wire

// File: rtl/gat_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gat_run_ctrl
//  Description : Sequences one GAT layer pass: waits for BRAM loads, starts
//                the core, and streams its output features into BRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module gat_run_ctrl
    import gat_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_SUBGRAPHS      = GAT_NUM_SUBGRAPHS,
    parameter int NUM_FEATURE_OUT    = GAT_NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          gat_start,
    input  logic                          gat_layer,
    input  logic                          h_data_bram_load_done,
    input  logic                          h_node_info_bram_load_done,
    input  logic                          wgt_bram_load_done,
    input  logic                          a_bram_load_done,
    output logic                          gat_ready,
    output logic                          busy,
    output logic                          core_start,
    output logic                          core_layer,
    input  logic                          feat_valid,
    input  logic [DATA_WIDTH-1:0]         feat_data,
    output logic                          feat_ready,
    output logic                          feat_bram_ena,
    output logic                          feat_bram_wea,
    output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addra,
    output logic [DATA_WIDTH-1:0]         feat_bram_din
);

    localparam logic [NEW_FEATURE_ADDR_W-1:0] c_last_addr =
        NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);

    gat_run_state_t                r_state;
    logic [NEW_FEATURE_ADDR_W-1:0] r_wr_cnt;
    logic                          r_core_start;
    logic                          r_core_layer;
    logic                          r_bram_en;
    logic [NEW_FEATURE_ADDR_W-1:0] r_bram_addr;
    logic [DATA_WIDTH-1:0]         r_bram_din;

    logic w_all_loaded;
    logic w_xfer;

    assign w_all_loaded = h_data_bram_load_done & h_node_info_bram_load_done &
                          wgt_bram_load_done & a_bram_load_done;
    assign w_xfer       = (r_state == RUN) & feat_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wr_cnt     <= '0;
            r_core_start <= 1'b0;
            r_core_layer <= 1'b0;
            r_bram_en    <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_din   <= '0;
        end else begin
            r_core_start <= 1'b0;
            r_bram_en    <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (gat_start) begin
                        r_core_layer <= gat_layer;
                        r_wr_cnt     <= '0;
                        r_state      <= WAIT_LOAD;
                    end
                end
                WAIT_LOAD: begin
                    // Flags are sampled live; a late drop afterwards is harmless.
                    if (w_all_loaded) begin
                        r_core_start <= 1'b1;
                        r_state      <= START;
                    end
                end
                START: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (w_xfer) begin
                        r_bram_en   <= 1'b1;
                        r_bram_addr <= r_wr_cnt;
                        r_bram_din  <= feat_data;
                        // Counter parks on the last address instead of wrapping.
                        if (r_wr_cnt == c_last_addr) begin
                            r_state <= DONE;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign feat_ready      = (r_state == RUN);
    assign busy            = (r_state == WAIT_LOAD) | (r_state == START) | (r_state == RUN);
    assign gat_ready       = (r_state == DONE);
    assign core_start      = r_core_start;
    assign core_layer      = r_core_layer;
    assign feat_bram_ena   = r_bram_en;
    assign feat_bram_wea   = r_bram_en;
    assign feat_bram_addra = r_bram_addr;
    assign feat_bram_din   = r_bram_din;

endmodule
`default_nettype wire

// File: tb/tb_gat_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gat_run_ctrl
//  Description : Scoreboard bench for gat_run_ctrl with an 8-word feature BRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gat_run_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          gat_start, gat_layer;
    logic          h_done, n_done, w_done, a_done;
    logic          gat_ready, busy, core_start, core_layer;
    logic          feat_valid;
    logic [DW-1:0] feat_data;
    logic          feat_ready, bram_ena, bram_wea;
    logic [AW-1:0] bram_addra;
    logic [DW-1:0] bram_din;

    gat_run_ctrl #(
        .DATA_WIDTH         (DW),
        .NUM_SUBGRAPHS      (1),
        .NUM_FEATURE_OUT    (DEPTH),
        .NEW_FEATURE_DEPTH  (DEPTH),
        .NEW_FEATURE_ADDR_W (AW)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .gat_start                  (gat_start),
        .gat_layer                  (gat_layer),
        .h_data_bram_load_done      (h_done),
        .h_node_info_bram_load_done (n_done),
        .wgt_bram_load_done         (w_done),
        .a_bram_load_done           (a_done),
        .gat_ready                  (gat_ready),
        .busy                       (busy),
        .core_start                 (core_start),
        .core_layer                 (core_layer),
        .feat_valid                 (feat_valid),
        .feat_data                  (feat_data),
        .feat_ready                 (feat_ready),
        .feat_bram_ena              (bram_ena),
        .feat_bram_wea              (bram_wea),
        .feat_bram_addra            (bram_addra),
        .feat_bram_din              (bram_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } wr_t;

    wr_t           exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [AW-1:0] exp_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic layer);
        gat_layer = layer;
        gat_start = 1'b1;
        tick();
        gat_start = 1'b0;
        exp_addr  = '0;
    endtask

    task automatic send(input logic [DW-1:0] d);
        wr_t w;
        chk("feat_ready_in_run", {31'd0, feat_ready}, 32'd1);
        w.addr = exp_addr;
        w.data = d;
        w.last = (exp_addr == AW'(DEPTH - 1));
        exp_q.push_back(w);
        exp_addr   = exp_addr + 1'b1;
        feat_valid = 1'b1;
        feat_data  = d;
        tick();
        feat_valid = 1'b0;
    endtask

    // Monitor: every BRAM strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && bram_ena) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {29'd0, bram_addra}, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", {29'd0, bram_addra}, {29'd0, w.addr});
                chk("wr_data", {24'd0, bram_din}, {24'd0, w.data});
                chk("wr_wea",  {31'd0, bram_wea}, 32'd1);
                chk("wr_ready_with_strobe", {31'd0, gat_ready}, {31'd0, w.last});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic bad;
        rst_n = 1'b0; gat_start = 1'b0; gat_layer = 1'b0;
        h_done = 1'b1; n_done = 1'b1; w_done = 1'b1; a_done = 1'b1;
        feat_valid = 1'b0; feat_data = '0; exp_addr = '0;
        repeat (3) tick();
        chk("rst_gat_ready",  {31'd0, gat_ready},  32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_core_start", {31'd0, core_start}, 32'd0);
        chk("rst_feat_ready", {31'd0, feat_ready}, 32'd0);
        chk("rst_bram_ena",   {31'd0, bram_ena},   32'd0);
        rst_n = 1'b1;
        tick();

        // Start with flags already high, layer 1.
        gat_layer = 1'b1;
        gat_start = 1'b1;
        chk("t0_busy", {31'd0, busy}, 32'd0);
        tick();
        gat_start = 1'b0; gat_layer = 1'b0; exp_addr = '0;
        chk("t1_busy",       {31'd0, busy},       32'd1);
        chk("t1_core_start", {31'd0, core_start}, 32'd0);
        chk("t1_core_layer", {31'd0, core_layer}, 32'd1);
        chk("t1_feat_ready", {31'd0, feat_ready}, 32'd0);
        tick();
        chk("t2_core_start", {31'd0, core_start}, 32'd1);
        tick();
        chk("t3_core_start", {31'd0, core_start}, 32'd0);

        // Abort a partial run after three writes.
        send(8'h55); send(8'h66); send(8'h77);
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy",       {31'd0, busy},       32'd0);
        chk("abort_feat_ready", {31'd0, feat_ready}, 32'd0);
        chk("abort_core_layer", {31'd0, core_layer}, 32'd0);
        chk("abort_addra",      {29'd0, bram_addra}, 32'd0);
        chk("abort_din",        {24'd0, bram_din},   32'd0);
        chk("abort_gat_ready",  {31'd0, gat_ready},  32'd0);
        rst_n = 1'b1;
        tick();

        // One flag low for 20 cycles holds the controller in WAIT_LOAD.
        a_done = 1'b0;
        pulse_start(1'b0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (core_start || !busy) bad = 1'b1;
            tick();
        end
        chk("wait_partial_flags", {31'd0, bad}, 32'd0);
        a_done = 1'b1;
        chk("flag_rise_core_start", {31'd0, core_start}, 32'd0);
        tick();
        chk("flag_next_core_start", {31'd0, core_start}, 32'd1);
        chk("flag_core_layer",      {31'd0, core_layer}, 32'd0);
        tick();

        // Eight back-to-back words from a fresh start write from address 0.
        for (int i = 0; i < DEPTH; i++) send(8'h10 + 8'(i));
        chk("b2b_gat_ready",  {31'd0, gat_ready},  32'd1);
        chk("b2b_last_addr",  {29'd0, bram_addra}, 32'd7);
        chk("b2b_last_din",   {24'd0, bram_din},   32'h17);
        chk("b2b_feat_ready", {31'd0, feat_ready}, 32'd0);
        feat_valid = 1'b1; feat_data = 8'hEE;
        tick();
        feat_valid = 1'b0;
        chk("done_valid_ignored", {31'd0, bram_ena},  32'd0);
        chk("done_gat_ready",     {31'd0, gat_ready}, 32'd1);

        // Restart from DONE, then a gappy stream with a stray start mid-run.
        pulse_start(1'b1);
        chk("restart_gat_ready", {31'd0, gat_ready},  32'd0);
        chk("restart_busy",      {31'd0, busy},       32'd1);
        tick();
        chk("restart_core_start", {31'd0, core_start}, 32'd1);
        tick();
        send(8'hA0);
        gat_start = 1'b1; gat_layer = 1'b0;
        tick();
        gat_start = 1'b0;
        chk("midrun_start_busy",  {31'd0, busy},       32'd1);
        chk("midrun_start_layer", {31'd0, core_layer}, 32'd1);
        h_done = 1'b0;
        send(8'hA1);
        for (int i = 2; i < DEPTH; i++) begin
            send(8'hA0 + 8'(i));
            if (i < DEPTH - 1) begin
                tick();
                chk("gap_no_write", {31'd0, bram_ena}, 32'd0);
            end
        end
        chk("rerun_gat_ready", {31'd0, gat_ready}, 32'd1);
        h_done = 1'b1;

        repeat (4) tick();
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
